// File: rtl/avalon_pio_out_pkg.sv
// Shared constants for the extended Avalon-MM output PIO: register addresses,
// STATUS bit positions and the PWM full-scale duty value.
package avalon_pio_out_pkg;

   localparam logic [2:0] ADDR_DATA       = 3'd0;
   localparam logic [2:0] ADDR_RSVD       = 3'd1;
   localparam logic [2:0] ADDR_BLINK_MASK = 3'd2;
   localparam logic [2:0] ADDR_PRESCALE   = 3'd3;
   localparam logic [2:0] ADDR_OUTSET     = 3'd4;
   localparam logic [2:0] ADDR_OUTCLEAR   = 3'd5;
   localparam logic [2:0] ADDR_STATUS     = 3'd6;
   localparam logic [2:0] ADDR_PWM        = 3'd7;

   localparam int unsigned STATUS_PHASE_BIT  = 0;
   localparam int unsigned STATUS_ACTIVE_BIT = 1;

   localparam logic [7:0] PWM_FULL = 8'hFF;

endpackage

// File: rtl/pio_blink_prescaler.sv
// Blink timebase: down-counter that reloads from the PRESCALE value and toggles
// phase on every underflow, giving a half-period of reload_val+1 clocks.
module pio_blink_prescaler
   import avalon_pio_out_pkg::*;
#(
   parameter logic [31:0] PRESCALE_RESET = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic [31:0] reload_val,
   output logic        phase,
   output logic        active
);

   logic [31:0] counter;

   assign active = (reload_val != 32'h0);

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its inputs, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         counter <= PRESCALE_RESET;
         phase   <= 1'b0;
      end else if (load) begin
         // A PRESCALE write restarts the half-period and wins over a due toggle.
         counter <= load_val;
         phase   <= 1'b0;
      end else if (!active) begin
         counter <= 32'h0;
         phase   <= 1'b0;
      end else if (counter == 32'h0) begin
         counter <= reload_val;
         phase   <= ~phase;
      end else begin
         counter <= counter - 32'd1;
      end
   end

endmodule

// File: rtl/avalon_pio_out_ext.sv
// Extended Avalon-MM output PIO: DATA/set/clear registers, blink engine,
// registered readback. Define AVALON_PIO_OUT_PWM_EN to build PWM dimming.
module avalon_pio_out_ext
   import avalon_pio_out_pkg::*;
#(
   parameter int          DATA_WIDTH     = 4,
   parameter logic [31:0] RESET_VALUE    = 32'h0,
   parameter logic [31:0] PRESCALE_RESET = 32'h0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [2:0]            address,
   input  logic                  chipselect,
   input  logic                  read_n,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   output logic [DATA_WIDTH-1:0] out_port
);

   localparam logic [DATA_WIDTH-1:0] DATA_RST = RESET_VALUE[DATA_WIDTH-1:0];

   logic                  wr;
   logic                  rd;
   logic [DATA_WIDTH-1:0] wd;
   logic [DATA_WIDTH-1:0] data;
   logic [DATA_WIDTH-1:0] blink_mask;
   logic [31:0]           prescale;
   logic                  phase;
   logic                  active;
   logic                  pwm_gate;
   logic [DATA_WIDTH-1:0] out_next;
   logic [31:0]           rd_mux;

   assign wr = chipselect & ~write_n;
   assign rd = chipselect & ~read_n;
   assign wd = writedata[DATA_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         data       <= DATA_RST;
         blink_mask <= '0;
         prescale   <= PRESCALE_RESET;
      end else if (wr) begin
         case (address)
            ADDR_DATA:       data       <= wd;
            ADDR_BLINK_MASK: blink_mask <= wd;
            ADDR_PRESCALE:   prescale   <= writedata;
            ADDR_OUTSET:     data       <= data | wd;
            ADDR_OUTCLEAR:   data       <= data & ~wd;
            default: ;
         endcase
      end
   end

   pio_blink_prescaler #(
      .PRESCALE_RESET(PRESCALE_RESET)
   ) u_blink (
      .clk        (clk),
      .reset      (reset),
      .load       (wr && (address == ADDR_PRESCALE)),
      .load_val   (writedata),
      .reload_val (prescale),
      .phase      (phase),
      .active     (active)
   );

`ifdef AVALON_PIO_OUT_PWM_EN
   logic [7:0] pwm_duty;
   logic [7:0] pwm_cnt;

   // The counter free-runs; duty writes never restart it.
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_duty <= PWM_FULL;
         pwm_cnt  <= 8'h00;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         if (wr && (address == ADDR_PWM)) pwm_duty <= writedata[7:0];
      end
   end

   assign pwm_gate = (pwm_cnt < pwm_duty) | (pwm_duty == PWM_FULL);
`else
   assign pwm_gate = 1'b1;
`endif

   assign out_next = data ^ (blink_mask & {DATA_WIDTH{phase}});

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      rd_mux = 32'h0;
      case (address)
         ADDR_DATA:       rd_mux = 32'(data);
         ADDR_BLINK_MASK: rd_mux = 32'(blink_mask);
         ADDR_PRESCALE:   rd_mux = prescale;
         ADDR_STATUS: begin
            rd_mux[STATUS_PHASE_BIT]  = phase;
            rd_mux[STATUS_ACTIVE_BIT] = active;
         end
`ifdef AVALON_PIO_OUT_PWM_EN
         ADDR_PWM:        rd_mux = 32'(pwm_duty);
`endif
         default:         rd_mux = 32'h0;
      endcase
   end

   // readdata captures pre-write register values, so a simultaneous read
   // and write returns the old contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= 32'h0;
         out_port <= DATA_RST;
      end else begin
         if (rd) readdata <= rd_mux;
         out_port <= out_next & {DATA_WIDTH{pwm_gate}};
      end
   end

endmodule

// File: tb/tb_avalon_pio_out_ext.sv
// Self-checking bench for avalon_pio_out_ext: a 4-bit and a 32-bit instance
// share one bus, selected by their individual chipselects.
module tb_avalon_pio_out_ext;
   import avalon_pio_out_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        cs4, cs32;
   logic        read_n, write_n;
   logic [31:0] writedata;
   logic [31:0] rd4, rd32;
   logic [3:0]  out4;
   logic [31:0] out32;

   always #5 clk = ~clk;

   avalon_pio_out_ext #(
      .DATA_WIDTH(4), .RESET_VALUE(32'hA), .PRESCALE_RESET(32'h0)
   ) dut4 (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs4),
      .read_n(read_n), .write_n(write_n), .writedata(writedata),
      .readdata(rd4), .out_port(out4)
   );

   avalon_pio_out_ext #(
      .DATA_WIDTH(32), .RESET_VALUE(32'h0), .PRESCALE_RESET(32'h0)
   ) dut32 (
      .clk(clk), .reset(reset), .address(address), .chipselect(cs32),
      .read_n(read_n), .write_n(write_n), .writedata(writedata),
      .readdata(rd32), .out_port(out32)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      bit          big;
      bit          is_wr;
      logic [2:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
      string       name;
   } vec_t;
   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sb_push(input string name, input logic [31:0] val);
      exp_t e;
      e.name = name;
      e.val  = val;
      exp_q.push_back(e);
   endtask

   task automatic sb_pop(input logic [31:0] act);
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty: got %h expected none", act);
      end else begin
         e = exp_q.pop_front();
         check(e.name, act, e.val);
      end
   endtask

   // One bus transaction: inputs driven at a negedge, committed at the next posedge.
   task automatic bus_cycle(input bit big, input bit do_rd, input bit do_wr,
                            input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      cs4 = !big; cs32 = big;
      read_n = !do_rd; write_n = !do_wr;
      address = a; writedata = d;
      @(negedge clk);
      cs4 = 1'b0; cs32 = 1'b0; read_n = 1'b1; write_n = 1'b1;
   endtask

   task automatic wr_chk(input bit big, input logic [2:0] a, input logic [31:0] d,
                         input string name, input logic [31:0] exp_out);
      sb_push(name, exp_out);
      bus_cycle(big, 1'b0, 1'b1, a, d);
      @(negedge clk);
      sb_pop(big ? out32 : 32'(out4));
   endtask

   task automatic rd_chk(input bit big, input logic [2:0] a, input string name,
                         input logic [31:0] exp);
      sb_push(name, exp);
      bus_cycle(big, 1'b1, 1'b0, a, 32'h0);
      sb_pop(big ? rd32 : rd4);
   endtask

   task automatic add(input bit big, input bit is_wr, input logic [2:0] a,
                      input logic [31:0] d, input logic [31:0] exp, input string name);
      vec_t v;
      v.big = big; v.is_wr = is_wr; v.addr = a; v.data = d; v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] pwm_rd_exp;
      int          hits;
      int          bad;

`ifdef AVALON_PIO_OUT_PWM_EN
      pwm_rd_exp = 32'hFF;
`else
      pwm_rd_exp = 32'h0;
`endif

      // Vectors: writes expect out_port one clk after the write edge, reads expect readdata.
      add(0, 0, ADDR_DATA,       32'h0,        32'hA,        "rd_data_reset");
      add(0, 1, ADDR_DATA,       32'h3,        32'h3,        "wr_data_3");
      add(0, 1, ADDR_OUTSET,     32'h8,        32'hB,        "outset_8");
      add(0, 1, ADDR_OUTCLEAR,   32'h1,        32'hA,        "outclear_1");
      add(0, 0, ADDR_OUTSET,     32'h0,        32'h0,        "rd_outset_zero");
      add(0, 0, ADDR_OUTCLEAR,   32'h0,        32'h0,        "rd_outclear_zero");
      add(0, 0, ADDR_DATA,       32'h0,        32'hA,        "rd_data_A");
      add(0, 1, ADDR_RSVD,       32'hF,        32'hA,        "wr_rsvd_ignored");
      add(0, 0, ADDR_RSVD,       32'h0,        32'h0,        "rd_rsvd_zero");
      add(0, 1, ADDR_DATA,       32'hFFFF_FFF5, 32'h5,       "wr_data_upper_ignored");
      add(0, 0, ADDR_DATA,       32'h0,        32'h5,        "rd_data_5");
      add(0, 1, ADDR_BLINK_MASK, 32'h6,        32'h5,        "wr_mask_no_blink");
      add(0, 0, ADDR_BLINK_MASK, 32'h0,        32'h6,        "rd_mask");
      add(0, 0, ADDR_STATUS,     32'h0,        32'h0,        "rd_status_idle");
      add(0, 0, ADDR_PWM,        32'h0,        pwm_rd_exp,   "rd_pwm_reset");
      add(0, 1, ADDR_PRESCALE,   32'h1234_5678, 32'h5,       "wr_prescale");
      add(0, 0, ADDR_PRESCALE,   32'h0,        32'h1234_5678, "rd_prescale");
      add(0, 0, ADDR_STATUS,     32'h0,        32'h2,        "rd_status_active");
      add(0, 1, ADDR_PRESCALE,   32'h0,        32'h5,        "wr_prescale_off");
      add(1, 1, ADDR_DATA,       32'hDEAD_BEEF, 32'hDEAD_BEEF, "w32_data");
      add(1, 0, ADDR_DATA,       32'h0,        32'hDEAD_BEEF, "w32_rd_data");
      add(1, 1, ADDR_RSVD,       32'h1234_5678, 32'hDEAD_BEEF, "w32_rsvd_ignored");
      add(1, 0, ADDR_DATA,       32'h0,        32'hDEAD_BEEF, "w32_rd_after_rsvd");
      add(1, 1, ADDR_OUTCLEAR,   32'hFFFF_0000, 32'h0000_BEEF, "w32_outclear");

      reset = 1'b1; cs4 = 1'b0; cs32 = 1'b0; read_n = 1'b1; write_n = 1'b1;
      address = 3'd0; writedata = 32'h0;
      repeat (3) @(negedge clk);
      check("reset_out4", 32'(out4), 32'hA);
      check("reset_rd4", rd4, 32'h0);
      check("reset_out32", out32, 32'h0);
      check("reset_rd32", rd32, 32'h0);
      reset = 1'b0;

      foreach (vecs[i]) begin
         if (vecs[i].is_wr) wr_chk(vecs[i].big, vecs[i].addr, vecs[i].data, vecs[i].name, vecs[i].exp);
         else               rd_chk(vecs[i].big, vecs[i].addr, vecs[i].name, vecs[i].exp);
      end

      // Simultaneous read and write: the read returns the pre-write value.
      sb_push("rdwr_old_value", 32'h0000_BEEF);
      bus_cycle(1'b1, 1'b1, 1'b1, ADDR_DATA, 32'h0000_0001);
      sb_pop(rd32);
      rd_chk(1'b1, ADDR_DATA, "rdwr_new_value", 32'h1);

      // Blink: PRESCALE=3 gives a 4-clk half-period on out_port[0].
      wr_chk(1'b0, ADDR_BLINK_MASK, 32'h1, "blink_mask_1", 32'h5);
      wr_chk(1'b0, ADDR_DATA, 32'h0, "blink_data_0", 32'h0);
      bus_cycle(1'b0, 1'b0, 1'b1, ADDR_PRESCALE, 32'd3);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         check($sformatf("blink_k%0d", k), 32'(out4[0]), 32'(((k - 1) / 4) % 2));
      end
      rd_chk(1'b0, ADDR_STATUS, "status_phase1", 32'h3);
      bus_cycle(1'b0, 1'b0, 1'b1, ADDR_PRESCALE, 32'd0);
      check("prescale_off_latency", 32'(out4), 32'h1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("prescale_off_k%0d", k), 32'(out4), 32'h0);
      end
      rd_chk(1'b0, ADDR_STATUS, "status_off", 32'h0);

      // Reset asserted while phase=1 aborts the blink cycle.
      wr_chk(1'b0, ADDR_DATA, 32'h2, "mid_data_2", 32'h2);
      rd_chk(1'b0, ADDR_DATA, "mid_rd_data", 32'h2);
      bus_cycle(1'b0, 1'b0, 1'b1, ADDR_PRESCALE, 32'd5);
      repeat (7) @(negedge clk);
      check("mid_phase1_out", 32'(out4), 32'h3);
      reset = 1'b1;
      @(negedge clk);
      check("mid_reset_out", 32'(out4), 32'hA);
      check("mid_reset_rd", rd4, 32'h0);
      reset = 1'b0;
      rd_chk(1'b0, ADDR_PRESCALE, "mid_reset_prescale", 32'h0);
      rd_chk(1'b0, ADDR_STATUS, "mid_reset_status", 32'h0);
      rd_chk(1'b0, ADDR_DATA, "mid_reset_data", 32'hA);

`ifdef AVALON_PIO_OUT_PWM_EN
      wr_chk(1'b0, ADDR_DATA, 32'hF, "pwm_data_F", 32'hF);
      bus_cycle(1'b0, 1'b0, 1'b1, ADDR_PWM, 32'd64);
      @(negedge clk);
      hits = 0; bad = 0;
      for (int k = 0; k < 256; k++) begin
         @(negedge clk);
         if (out4 == 4'hF) hits++;
         else if (out4 != 4'h0) bad++;
      end
      check("pwm64_high_count", 32'(hits), 32'd64);
      check("pwm64_bad_levels", 32'(bad), 32'd0);
      rd_chk(1'b0, ADDR_PWM, "pwm_rd_duty", 32'd64);

      bus_cycle(1'b0, 1'b0, 1'b1, ADDR_PWM, 32'd0);
      @(negedge clk);
      hits = 0;
      for (int k = 0; k < 256; k++) begin
         @(negedge clk);
         if (out4 != 4'h0) hits++;
      end
      check("pwm0_nonzero_count", 32'(hits), 32'd0);

      bus_cycle(1'b0, 1'b0, 1'b1, ADDR_PWM, 32'd255);
      @(negedge clk);
      hits = 0;
      for (int k = 0; k < 256; k++) begin
         @(negedge clk);
         if (out4 != 4'hF) hits++;
      end
      check("pwm255_not_full_count", 32'(hits), 32'd0);
`endif

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
